// File: rtl/vm_change_dispenser.sv
// Change dispenser: greedy 50/10 coin ejection with a per-coin handshake on coin_ack.
// Latency: first coin pulse 2 cycles after the request; done 2 cycles after the last ack (2 cycles after the request for value < 10).
// Backpressure: a request is accepted only in IDLE. Each coin waits for coin_ack; optional timeout via macro VMCD_ACK_TIMEOUT_EN.
module vm_change_dispenser #(
    parameter int ACK_TO = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       change_return,
    input  logic [7:0] value,
    input  logic       coin_ack,
    output logic       coin_50,
    output logic       coin_10,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] remaining,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISPENSE,
        S_WAIT,
        S_DONE,
        S_FAULT
    } state_t;

    state_t state;
    logic   residue;   // request had a remainder that cannot be paid out
    logic   is_50;     // denomination of the coin currently awaiting ack
    logic   pulse_now; // first WAIT cycle: the coin pulse itself is on the output

    assign pulse_now = coin_50 | coin_10;

    // An ACK_TO of zero would make the timeout fire before any ack could arrive
    if (ACK_TO < 1) begin : g_ack_to_check
        $error("ACK_TO must be at least 1");
    end

`ifdef VMCD_ACK_TIMEOUT_EN
    localparam int CW = $clog2(ACK_TO + 1);
    logic [CW-1:0] to_cnt;
`else
    assign fault = 1'b0;
`endif

    // Main controller: all outputs are registered and pulses self-clear each cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            remaining <= 8'd0;
            coin_50   <= 1'b0;
            coin_10   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            residue   <= 1'b0;
            is_50     <= 1'b0;
`ifdef VMCD_ACK_TIMEOUT_EN
            fault     <= 1'b0;
            to_cnt    <= '0;
`endif
        end else begin
            coin_50 <= 1'b0;
            coin_10 <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (change_return) begin
                        remaining <= value - (value % 8'd10);
                        residue   <= (value % 8'd10) != 8'd0;
                        busy      <= 1'b1;
                        state     <= S_DISPENSE;
                    end
                end
                S_DISPENSE: begin
`ifdef VMCD_ACK_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                    if (remaining >= 8'd50) begin
                        coin_50 <= 1'b1;
                        is_50   <= 1'b1;
                        state   <= S_WAIT;
                    end else if (remaining >= 8'd10) begin
                        coin_10 <= 1'b1;
                        is_50   <= 1'b0;
                        state   <= S_WAIT;
                    end else begin
                        done  <= 1'b1;
                        err   <= residue;
                        state <= S_DONE;
                    end
                end
                S_WAIT: begin
                    // An ack in the same cycle as the pulse cannot refer to this coin
                    if (coin_ack && !pulse_now) begin
                        remaining <= remaining - (is_50 ? 8'd50 : 8'd10);
                        state     <= S_DISPENSE;
                    end
`ifdef VMCD_ACK_TIMEOUT_EN
                    else if (!pulse_now) begin
                        if (to_cnt == CW'(ACK_TO - 1)) begin
                            fault <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_FAULT;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
`endif
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_FAULT: begin
                    state <= S_FAULT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Bench for vm_change_dispenser: per-cycle expected outputs are planned from the request list.
// Directed requests first (fixed cycles, literal checks), then randomized requests with noise.
// Ack timing is chosen by the bench, so the whole expected waveform is known up front.
module tb_vm_change_dispenser;

    localparam int ACK_TO = 15;
    localparam int MAXC   = 4000;

    logic       clk = 1'b0;
    logic       rst;
    logic       change_return;
    logic [7:0] value;
    logic       coin_ack;
    logic       coin_50;
    logic       coin_10;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] remaining;
    logic       fault;

    always #5 clk = ~clk;

    vm_change_dispenser #(.ACK_TO(ACK_TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .change_return (change_return),
        .value         (value),
        .coin_ack      (coin_ack),
        .coin_50       (coin_50),
        .coin_10       (coin_10),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .remaining     (remaining),
        .fault         (fault)
    );

    typedef struct packed {
        logic       c50;
        logic       c10;
        logic       busy;
        logic       done;
        logic       err;
        logic       fault;
        logic [7:0] rem;
    } obs_t;

    obs_t       exp_o  [MAXC];
    bit         in_rst [MAXC];
    bit         in_cr  [MAXC];
    bit         in_ack [MAXC];
    logic [7:0] in_val [MAXC];

    int cur      = 0;
    int last_cyc = 0;
    int cyc      = 0;
    int passed   = 0;
    int total    = 0;

    function automatic obs_t mk(input bit b, input int r);
        obs_t o;
        o      = '0;
        o.busy = b;
        o.rem  = 8'(r);
        return o;
    endfunction

    // Plan one request starting at cycle cur; dly = 0 picks random ack delays
    task automatic txn(input int v, input int dly, input bit abort, input bit noise);
        int n, t, p, d, rem, denom;
        bit res;
        n         = cur;
        in_cr[n]  = 1'b1;
        in_val[n] = 8'(v);
        rem       = (v / 10) * 10;
        res       = (v % 10) != 0;
        t         = n + 1;
        exp_o[t]  = mk(1'b1, rem);
        while (rem >= 10) begin
            denom = (rem >= 50) ? 50 : 10;
            if (noise) in_ack[t] = 1'($urandom_range(0, 1));
            p = t + 1;
            d = (dly > 0) ? dly : int'($urandom_range(1, 4));
            for (int k = p; k <= p + d; k++) exp_o[k] = mk(1'b1, rem);
            exp_o[p].c50 = (denom == 50);
            exp_o[p].c10 = (denom == 10);
            if (noise) in_ack[p] = 1'($urandom_range(0, 1));
            in_ack[p + d] = 1'b1;
            if (abort) begin
                in_rst[p] = 1'b0;
                for (int k = p + 1; k <= p + d; k++) begin
                    exp_o[k]  = '0;
                    in_ack[k] = 1'b0;
                end
                cur = p + 1;
                return;
            end
            rem      = rem - denom;
            t        = p + d + 1;
            exp_o[t] = mk(1'b1, rem);
        end
        exp_o[t + 1]      = mk(1'b1, rem);
        exp_o[t + 1].done = 1'b1;
        exp_o[t + 1].err  = res;
        if (noise) begin
            in_ack[t + 1] = 1'($urandom_range(0, 1));
            for (int k = n + 1; k <= t + 1; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    in_cr[k]  = 1'b1;
                    in_val[k] = 8'($urandom_range(0, 255));
                end
            end
        end
        cur = t + 2;
    endtask

    // Final request whose coin is never acknowledged
    task automatic hang_txn();
        int n, p;
        n         = cur;
        in_cr[n]  = 1'b1;
        in_val[n] = 8'd10;
        exp_o[n + 1] = mk(1'b1, 10);
        p = n + 2;
        for (int k = p; k <= p + 40; k++) begin
`ifdef VMCD_ACK_TIMEOUT_EN
            if (k <= p + ACK_TO) exp_o[k] = mk(1'b1, 10);
            else begin
                exp_o[k]       = mk(1'b0, 10);
                exp_o[k].fault = 1'b1;
            end
`else
            exp_o[k] = mk(1'b1, 10);
`endif
        end
        exp_o[p].c10   = 1'b1;
        in_cr[p + 30]  = 1'b1;
        in_val[p + 30] = 8'd100;
        last_cyc       = p + 40;
    endtask

    task automatic apply(input int c);
        rst           = in_rst[c];
        change_return = in_cr[c];
        value         = in_val[c];
        coin_ack      = in_ack[c];
    endtask

    task automatic lit(input string nm, input int act, input int want);
        total++;
        if (act == want) passed++;
        else $display("FAIL %s cycle %0d: got %0d, want %0d", nm, cyc, act, want);
    endtask

    // Stimulus planning and cycle-by-cycle drive
    initial begin
        int v, g;
        for (int i = 0; i < MAXC; i++) begin
            exp_o[i]  = '0;
            in_rst[i] = 1'b1;
            in_cr[i]  = 1'b0;
            in_ack[i] = 1'b0;
            in_val[i] = 8'($urandom_range(0, 255));
        end
        in_rst[0] = 1'b0;
        in_rst[1] = 1'b0;
        cur = 2;
        txn(130, 1, 1'b0, 1'b0);   // cycles 2..19
        txn(0, 1, 1'b0, 1'b0);     // cycles 20..22
        txn(7, 1, 1'b0, 1'b0);     // cycles 23..25
        txn(60, 2, 1'b0, 1'b0);    // cycles 26..36
        in_cr[29]  = 1'b1;
        in_val[29] = 8'd200;
        txn(100, 1, 1'b1, 1'b0);   // reset at cycle 39
        txn(255, 3, 1'b0, 1'b0);   // cycles 40..67
        for (int i = 0; i < 45; i++) begin
            if (cur < MAXC - 200) begin
                g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++) begin
                    in_ack[cur] = 1'($urandom_range(0, 1));
                    cur++;
                end
                case ($urandom_range(0, 3))
                    0:       v = $urandom_range(0, 9);
                    1:       v = 10 * $urandom_range(0, 25);
                    default: v = $urandom_range(0, 255);
                endcase
                txn(v, 0, ($urandom_range(0, 9) == 0), 1'b1);
            end
        end
        hang_txn();

        apply(0);
        for (int c = 1; c <= last_cyc; c++) begin
            @(posedge clk);
            cyc = c;
            #1;
            apply(c);
        end
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Compare DUT outputs against the plan every cycle, plus hand-computed points
    always @(negedge clk) begin
        obs_t act;
        if (cyc >= 1 && cyc <= last_cyc) begin
            act = {coin_50, coin_10, busy, done, err, fault, remaining};
            total++;
            if (act === exp_o[cyc]) passed++;
            else $display("FAIL cycle_%0d: got c50=%b c10=%b busy=%b done=%b err=%b fault=%b rem=%0d, want c50=%b c10=%b busy=%b done=%b err=%b fault=%b rem=%0d",
                          cyc, act.c50, act.c10, act.busy, act.done, act.err, act.fault, act.rem,
                          exp_o[cyc].c50, exp_o[cyc].c10, exp_o[cyc].busy, exp_o[cyc].done,
                          exp_o[cyc].err, exp_o[cyc].fault, exp_o[cyc].rem);
            case (cyc)
                1:  lit("reset_busy", int'(busy), 0);
                3:  lit("v130_rem_start", int'(remaining), 130);
                4:  lit("v130_first_50", int'(coin_50), 1);
                6:  lit("v130_rem_80", int'(remaining), 80);
                9:  lit("v130_rem_30", int'(remaining), 30);
                10: lit("v130_first_10", int'(coin_10), 1);
                18: lit("v130_rem_0", int'(remaining), 0);
                19: lit("v130_done", int'({done, err}), 2);
                22: lit("v0_done_noerr", int'({done, err}), 2);
                25: lit("v7_done_err", int'({done, err}), 3);
                30: lit("v60_ignores_200", int'(remaining), 60);
                32: lit("v60_second_10", int'(coin_10), 1);
                36: lit("v60_done", int'(done), 1);
                40: lit("abort_quiet", int'({coin_50, busy, remaining}), 0);
                66: lit("v255_rem_0", int'(remaining), 0);
                67: lit("v255_done_err", int'({done, err}), 3);
                default: ;
            endcase
        end
    end

endmodule
